// File: rtl/data_read_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// data_read_arbiter : round-robin arbiter sharing one data-read port among NREQ
// requesters; DATA_ARB_TIMEOUT_EN adds a stall timeout with a sticky err flag.
// Revision: 1.0
// ============================================================================
module data_read_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 128,
  parameter int MAX_BEATS = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ-1:0]         req_last_i,
  input  logic [NREQ*DW-1:0]      req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DW-1:0]           out_data_o,
  output logic [$clog2(NREQ)-1:0] out_src_o,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int          SW          = $clog2(NREQ);
  localparam logic [0:0]  C_IDLE      = 1'b0;
  localparam logic [0:0]  C_XFER      = 1'b1;
  localparam logic [8:0]  C_MAX_BEATS = 9'(MAX_BEATS);

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SW-1:0]   src_q, src_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            w_busy;
  logic            w_gvalid;
  logic            w_accept;
  logic            w_end;
  logic            w_timeout;
  logic [SW-1:0]   w_pick;

  assign w_busy   = (state_q == C_XFER);
  assign w_gvalid = req_valid_i[src_q];
  assign w_accept = w_busy & w_gvalid & out_ready_i;
  // A last beat that also reaches the cap is still a single grant end.
  assign w_end    = w_accept & (req_last_i[src_q] | (({1'b0, cnt_q} + 9'd1) == C_MAX_BEATS));

  // First valid requester searching upward from ptr+1 with wrap-around.
  always_comb begin
    logic          found;
    logic [SW-1:0] idx;
    w_pick = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = SW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid_i[idx]) begin
        w_pick = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= C_IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      ptr_q   <= SW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_IDLE: begin
        if (|req_valid_i) begin
          gnt_d   = NREQ'(1) << w_pick;
          src_d   = w_pick;
          cnt_d   = '0;
          state_d = C_XFER;
        end
      end
      default: begin
        if (w_accept) cnt_d = cnt_q + 8'd1;
        if (w_end || w_timeout) begin
          gnt_d   = '0;
          ptr_d   = src_q;
          state_d = C_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    out_valid_o = w_busy & w_gvalid;
    req_ready_o = gnt_q & {NREQ{w_busy & out_ready_i}};
    out_data_o  = req_data_i[int'(src_q)*DW +: DW];
  end

  assign gnt_o     = gnt_q;
  assign out_src_o = src_q;
  assign busy_o    = w_busy;

`ifdef DATA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  assign w_timeout = w_busy & ~w_gvalid & (stall_q == TW'(TIMEOUT - 1));

  always_comb begin
    stall_d = stall_q + TW'(1);
    if (!w_busy || w_gvalid || w_timeout) stall_d = '0;
    err_d = err_q | w_timeout;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // Stall release disabled: a stalled requester keeps its grant.
  assign w_timeout = (TIMEOUT < 0);
  assign err_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_read_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_data_read_arbiter : vector table, directed corner sequences and a random
// run against a transaction-level round-robin model. Revision: 1.0
// ============================================================================
module tb_data_read_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 128;
  localparam int MAXB = 16;
  localparam int TMO  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_src;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              err;

  data_read_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BEATS(MAXB), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
    .req_ready_o(req_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_src_o(out_src), .gnt_o(gnt),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Packed control view: {gnt, busy, out_valid, req_ready, out_src}
  task automatic chk_ctl(input string name, input logic [3:0] g, input logic b,
                         input logic ov, input logic [3:0] rr, input logic [1:0] s);
    chk(name, DW'({gnt, busy, out_valid, req_ready, out_src}), DW'({g, b, ov, rr, s}));
  endtask

  function automatic logic [DW-1:0] dat(input int i, input int s);
    return DW'((i + 1) * 256 + s);
  endfunction

  task automatic set_data(input int s);
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dat(i, s);
  endtask

  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic r);
    @(negedge clk);
    req_valid = v;
    req_last  = l;
    out_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_last = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return ptr;
  endfunction

  typedef struct {
    logic [3:0] v; logic [3:0] l; logic r;
    logic [3:0] gnt; logic busy; logic ov; logic [3:0] rr; logic [1:0] src;
  } vec_t;

  vec_t tbl[14];

  logic [DW-1:0] qd[NREQ][$];
  bit            ql[NREQ][$];
  bit            pres[NREQ];

  initial begin
    int b;
    tbl[0]  = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[1]  = '{4'h4, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[2]  = '{4'h4, 4'h0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2};
    tbl[3]  = '{4'h4, 4'h0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2};
    tbl[4]  = '{4'h4, 4'h4, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd2};
    tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 4'h8, 2'd3};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd3};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 2'd0};
    tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[10] = '{4'hF, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 2'd1};
    tbl[11] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 2'd1};
    tbl[12] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd1};
    tbl[13] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd1};

    // Vector table: single requester burst, then round-robin rotation
    do_reset();
    for (int s = 0; s < 14; s++) begin
      set_data(s);
      cyc(tbl[s].v, tbl[s].l, tbl[s].r);
      chk_ctl($sformatf("tbl_ctl[%0d]", s), tbl[s].gnt, tbl[s].busy, tbl[s].ov, tbl[s].rr, tbl[s].src);
      if (tbl[s].ov) chk($sformatf("tbl_data[%0d]", s), out_data, dat(int'(tbl[s].src), s));
      if (s == 0) chk("reset_err", DW'(err), DW'(0));
    end

    // Burst cap: req 1 streams without last, others wait
    do_reset();
    set_data(0);
    cyc(4'b0010, 4'b0000, 1'b1);
    chk_ctl("cap_idle", 4'h0, 1'b0, 1'b0, 4'h0, 2'd0);
    for (int k = 0; k < MAXB; k++) begin
      set_data(k);
      cyc(4'b0111, 4'b0101, 1'b1);
      chk_ctl($sformatf("cap_beat[%0d]", k), 4'h2, 1'b1, 1'b1, 4'h2, 2'd1);
      chk($sformatf("cap_data[%0d]", k), out_data, dat(1, k));
    end
    cyc(4'b0111, 4'b0101, 1'b1);
    chk_ctl("cap_release", 4'h0, 1'b0, 1'b0, 4'h0, 2'd1);
    cyc(4'b0111, 4'b0101, 1'b1);
    chk_ctl("cap_next2", 4'h4, 1'b1, 1'b1, 4'h4, 2'd2);
    cyc(4'b0011, 4'b0001, 1'b1);
    chk_ctl("cap_idle2", 4'h0, 1'b0, 1'b0, 4'h0, 2'd2);
    cyc(4'b0011, 4'b0001, 1'b1);
    chk_ctl("cap_next0", 4'h1, 1'b1, 1'b1, 4'h1, 2'd0);
    cyc(4'b0010, 4'b0000, 1'b1);
    chk_ctl("cap_idle3", 4'h0, 1'b0, 1'b0, 4'h0, 2'd0);
    cyc(4'b0010, 4'b0000, 1'b1);
    chk_ctl("cap_regrant1", 4'h2, 1'b1, 1'b1, 4'h2, 2'd1);

    // Backpressure: out_ready 1,0,1,0,... over a 4-beat burst from req 0
    do_reset();
    req_data[0 +: DW] = dat(0, 0);
    cyc(4'b0001, 4'b0000, 1'b1);
    chk_ctl("bp_idle", 4'h0, 1'b0, 1'b0, 4'h0, 2'd0);
    b = 0;
    for (int c = 0; c < 7; c++) begin
      req_data[0 +: DW] = dat(0, b);
      cyc(4'b0001, (b == 3) ? 4'b0001 : 4'b0000, (c % 2) == 0);
      chk_ctl($sformatf("bp_ctl[%0d]", c), 4'h1, 1'b1, 1'b1, ((c % 2) == 0) ? 4'h1 : 4'h0, 2'd0);
      chk($sformatf("bp_data[%0d]", c), out_data, dat(0, b));
      if ((c % 2) == 0) b++;
    end
    cyc(4'b0000, 4'b0000, 1'b1);
    chk_ctl("bp_end", 4'h0, 1'b0, 1'b0, 4'h0, 2'd0);

    // Reset mid-burst: req 3 sends 2 beats, reset lands with beat 3 pending
    do_reset();
    cyc(4'b1000, 4'b0000, 1'b1);
    cyc(4'b1000, 4'b0000, 1'b1);
    cyc(4'b1000, 4'b0000, 1'b1);
    chk_ctl("mid_beat2", 4'h8, 1'b1, 1'b1, 4'h8, 2'd3);
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b0; #1;
    chk_ctl("mid_pre_rst", 4'h8, 1'b1, 1'b1, 4'h0, 2'd3);
    @(negedge clk); #1;
    chk_ctl("mid_rst", 4'h0, 1'b0, 1'b0, 4'h0, 2'd0);
    chk("mid_rst_err", DW'(err), DW'(0));
    rst_n = 1'b1; req_valid = 4'b1001; out_ready = 1'b1;
    cyc(4'b1001, 4'b0000, 1'b1);
    chk_ctl("mid_first0", 4'h1, 1'b1, 1'b1, 4'h1, 2'd0);

    // Stalled requester: forced release with the timeout, held without it
    do_reset();
    cyc(4'b1000, 4'b0000, 1'b1);
    cyc(4'b1000, 4'b0000, 1'b1);
    chk_ctl("to_beat", 4'h8, 1'b1, 1'b1, 4'h8, 2'd3);
    for (int t = 0; t < TMO; t++) begin
      cyc(4'b0001, 4'b0000, 1'b1);
      if (t == 0 || t == TMO - 1) chk_ctl($sformatf("to_hold[%0d]", t), 4'h8, 1'b1, 1'b0, 4'h8, 2'd3);
    end
    cyc(4'b0001, 4'b0001, 1'b1);
`ifdef DATA_ARB_TIMEOUT_EN
    chk_ctl("to_release", 4'h0, 1'b0, 1'b0, 4'h0, 2'd3);
    chk("to_err", DW'(err), DW'(1));
    cyc(4'b0001, 4'b0001, 1'b1);
    chk_ctl("to_next0", 4'h1, 1'b1, 1'b1, 4'h1, 2'd0);
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("to_err_sticky", DW'(err), DW'(1));
`else
    chk_ctl("stall_held", 4'h8, 1'b1, 1'b0, 4'h8, 2'd3);
    chk("stall_err", DW'(err), DW'(0));
`endif

    // Random traffic against a transaction-level round-robin model
    begin
      int total, seen, m_ptr, m_g, m_cnt, guard;
      bit m_busy, done;
      logic [3:0] v, l, e_gnt, e_rr;
      logic r, lastb;
      do_reset();
      total = 0; seen = 0; m_ptr = NREQ - 1; m_g = 0; m_cnt = 0; m_busy = 0; guard = 0;
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = 0; pres[i] = 0;
        while (n < 30) begin
          int len;
          len = $urandom_range(1, 20);
          for (int j = 0; j < len; j++) begin
            qd[i].push_back({$urandom, $urandom, $urandom, $urandom});
            ql[i].push_back(j == len - 1);
            total++;
          end
          n += len;
        end
      end
      done = 0;
      while (!done) begin
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
          if (!pres[i] && qd[i].size() > 0 && $urandom_range(3) != 0) pres[i] = 1;
          v[i] = pres[i];
          l[i] = pres[i] ? ql[i][0] : 1'($urandom_range(1));
          req_data[i*DW +: DW] = pres[i] ? qd[i][0] : DW'($urandom);
        end
        r = ($urandom_range(3) != 0);
        req_valid = v; req_last = l; out_ready = r;
        #1;
        e_gnt = m_busy ? 4'(1 << m_g) : 4'h0;
        e_rr  = (m_busy && r) ? 4'(1 << m_g) : 4'h0;
        chk_ctl("rnd_ctl", e_gnt, m_busy, m_busy & v[m_g], e_rr, 2'(m_g));
        if (m_busy && v[m_g]) chk("rnd_data", out_data, qd[m_g][0]);
        if (err !== 1'b0) chk("rnd_err", DW'(err), DW'(0));
        if (out_valid && out_ready) seen++;
        if (!m_busy) begin
          if (|v) begin m_g = pick(v, m_ptr); m_busy = 1; m_cnt = 0; end
        end else if (v[m_g] && r) begin
          lastb = ql[m_g][0];
          void'(qd[m_g].pop_front());
          void'(ql[m_g].pop_front());
          pres[m_g] = 0;
          m_cnt++;
          if (lastb || m_cnt == MAXB) begin m_busy = 0; m_ptr = m_g; end
        end
        guard++;
        done = !m_busy && qd[0].size() == 0 && qd[1].size() == 0 && qd[2].size() == 0 && qd[3].size() == 0;
        if (guard >= 20000) begin
          chk("rnd_drain_timeout", DW'(0), DW'(1));
          done = 1;
        end
      end
      chk("rnd_beats", DW'(seen), DW'(total));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
